// File: rtl/membrane_accumulator.sv
// rtl/membrane_accumulator.sv - leaky integrate-and-fire membrane accumulator with refractory period
module membrane_accumulator #(
    parameter int                 NUM_SYN = 8,
    parameter int                 LEAK    = 1,
    parameter int                 REFRAC  = 2,
    parameter logic signed [7:0]  V_RESET = 8'sd0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SYN-1:0]        in_spk,
    input  logic [8*NUM_SYN-1:0]      weights,
    input  logic                      spk_in,
    output logic signed [7:0]         acc_out,
    output logic                      out_valid
);

    localparam int IW = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
    localparam int CW = $clog2(REFRAC + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_LEAK,
        S_CHECK,
        S_REFRAC
    } state_t;

    state_t                 state, state_nxt;
    logic signed [7:0]      acc;
    logic [IW-1:0]          idx;
    logic [CW-1:0]          cnt;
    logic [NUM_SYN-1:0]     spk_q;
    logic [8*NUM_SYN-1:0]   w_q;

    logic signed [7:0]      w_sel;
    logic                   s_sel;
    logic signed [8:0]      sum9;
    logic signed [7:0]      acc_sat;
    logic signed [7:0]      acc_leak;
    logic                   idx_last;

    assign acc_out  = acc;
    assign idx_last = (idx == IW'(NUM_SYN - 1));

    // Select the current synapse's latched spike bit and weight
    always_comb begin
        w_sel = '0;
        s_sel = 1'b0;
        for (int i = 0; i < NUM_SYN; i++) begin
            if (int'(idx) == i) begin
                w_sel = w_q[8*i +: 8];
                s_sel = spk_q[i];
            end
        end
    end

    // Saturating add in 9 bits, then leak toward zero without crossing it
    always_comb begin
        sum9 = {acc[7], acc} + {w_sel[7], w_sel};
        if (sum9 > 9'sd127) begin
            acc_sat = 8'sd127;
        end else if (sum9 < -9'sd128) begin
            acc_sat = -8'sd128;
        end else begin
            acc_sat = sum9[7:0];
        end

        acc_leak = acc;
        if (acc > 8'sd0) begin
            acc_leak = (int'(acc) > LEAK) ? acc - 8'(LEAK) : 8'sd0;
        end else if (acc < 8'sd0) begin
            acc_leak = (-int'(acc) > LEAK) ? acc + 8'(LEAK) : 8'sd0;
        end
    end

    // Next-state logic and handshake/strobe outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                if (idx_last) state_nxt = S_LEAK;
            end
            S_LEAK: begin
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                out_valid = 1'b1;
                if (spk_in && (REFRAC > 0)) state_nxt = S_REFRAC;
                else                        state_nxt = S_IDLE;
            end
            S_REFRAC: begin
                if (cnt <= CW'(1)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and membrane datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            idx   <= '0;
            cnt   <= '0;
            spk_q <= '0;
            w_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        spk_q <= in_spk;
                        w_q   <= weights;
                        idx   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (s_sel) acc <= acc_sat;
                    if (!idx_last) idx <= idx + IW'(1);
                end
                S_LEAK: begin
                    acc <= acc_leak;
                end
                S_CHECK: begin
                    if (spk_in) begin
                        acc <= V_RESET;
                        cnt <= CW'(REFRAC);
                    end
                end
                S_REFRAC: begin
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_membrane_accumulator.sv
// tb/tb_membrane_accumulator.sv - directed table-driven bench for membrane_accumulator
module tb_membrane_accumulator;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_spk;
    logic [31:0]       weights;
    logic              spk_in;
    logic signed [7:0] acc_out;
    logic              out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    membrane_accumulator #(
        .NUM_SYN (4),
        .LEAK    (1),
        .REFRAC  (2),
        .V_RESET (8'sd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_spk    (in_spk),
        .weights   (weights),
        .spk_in    (spk_in),
        .acc_out   (acc_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Downstream threshold comparator, threshold 10
    assign spk_in = (acc_out >= 8'sd10);

    typedef struct {
        logic [3:0]  spk;
        logic [31:0] w;
        int          exp_acc;
        bit          exp_spk;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run_step(input vec_t v, input int n);
        int  ov_k, rdy_k, pulses, acc_ov, acc_rdy, spk_ov;
        bit  hs;
        hs = 0;
        for (int i = 0; i < 30 && !hs; i++) begin
            @(negedge clk);
            if (in_ready) hs = 1;
        end
        check($sformatf("v%0d_ready_before", n), int'(hs), 1);
        in_spk   = v.spk;
        weights  = v.w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_spk   = 4'($urandom);
        weights  = $urandom;
        ov_k = -1; rdy_k = -1; pulses = 0; acc_ov = 999; acc_rdy = 999; spk_ov = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (ov_k < 0) begin
                    ov_k   = k;
                    acc_ov = int'(acc_out);
                    spk_ov = int'(spk_in);
                end
            end
            if (in_ready && rdy_k < 0) begin
                rdy_k   = k;
                acc_rdy = int'(acc_out);
            end
        end
        check($sformatf("v%0d_ov_latency", n), ov_k, 6);
        check($sformatf("v%0d_ov_pulses", n), pulses, 1);
        check($sformatf("v%0d_acc_at_ov", n), acc_ov, v.exp_acc);
        check($sformatf("v%0d_spike", n), spk_ov, int'(v.exp_spk));
        check($sformatf("v%0d_ready_latency", n), rdy_k, v.exp_spk ? 9 : 7);
        check($sformatf("v%0d_acc_after", n), acc_rdy, v.exp_spk ? 0 : v.exp_acc);
    endtask

    initial begin
        int ov1, ov2, acc1, acc2, rdy_first, rdy_count, pulses;
        bit bad_pulse;

        vecs[0] = '{4'b0101, {8'd5,   8'd7,   8'd9,   8'd4  },   10, 1'b1};
        vecs[1] = '{4'b1111, {8'h64,  8'h64,  8'h64,  8'h64 },  126, 1'b1};
        vecs[2] = '{4'b1111, {8'h9C,  8'h9C,  8'h9C,  8'h9C }, -127, 1'b0};
        vecs[3] = '{4'b1111, {8'h64,  8'h64,  8'h64,  8'h64 },  126, 1'b1};
        vecs[4] = '{4'b0001, {8'd0,   8'd0,   8'd0,   8'd3  },    2, 1'b0};
        vecs[5] = '{4'b0001, {8'd0,   8'd0,   8'd0,   8'd3  },    4, 1'b0};
        vecs[6] = '{4'b0000, {8'h7F,  8'h7F,  8'h7F,  8'h7F },    3, 1'b0};
        vecs[7] = '{4'b1010, {8'hFF,  8'h7F,  8'hFD,  8'h7F },    0, 1'b0};
        vecs[8] = '{4'b1010, {8'hFF,  8'h7F,  8'hFD,  8'h7F },   -3, 1'b0};
        vecs[9] = '{4'b0000, {8'd0,   8'd0,   8'd0,   8'd0  },   -2, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_spk   = 4'hF;
        weights  = 32'h7F7F7F7F;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_acc", int'(acc_out), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++) run_step(vecs[i], i);

        // Reset in the middle of accumulation abandons the timestep
        @(negedge clk);
        in_spk   = 4'b0001;
        weights  = {8'd0, 8'd0, 8'd0, 8'd3};
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_acc", int'(acc_out), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        bad_pulse = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) bad_pulse = 1;
        end
        check("midrst_no_out_valid", int'(bad_pulse), 0);

        // in_valid held through refractory: no acceptance until IDLE
        in_spk   = 4'b0101;
        weights  = {8'd5, 8'd7, 8'd9, 8'd4};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_spk  = 4'b0000;
        weights = $urandom;
        ov1 = -1; ov2 = -1; acc1 = 999; acc2 = 999;
        rdy_first = -1; rdy_count = 0; pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (ov1 < 0) begin
                    ov1 = k; acc1 = int'(acc_out);
                end else if (ov2 < 0) begin
                    ov2 = k; acc2 = int'(acc_out);
                end
            end
            if (in_ready) begin
                rdy_count++;
                if (rdy_first < 0) begin
                    rdy_first = k;
                    @(posedge clk);
                    #1 in_valid = 1'b0;
                end
            end
        end
        check("hold_first_ov", ov1, 6);
        check("hold_first_acc", acc1, 10);
        check("hold_ready_first", rdy_first, 9);
        check("hold_ready_count", rdy_count, 1);
        check("hold_second_ov", ov2, 15);
        check("hold_second_acc", acc2, 0);
        check("hold_pulses", pulses, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/membrane_accumulator.md
MEMBRANE_ACCUMULATOR -- requirements
Module: membrane_accumulator

Interface
REQ-001 Parameter NUM_SYN, default 8: number of synaptic inputs per timestep.
REQ-002 Parameter LEAK, default 1: unsigned leak magnitude applied once per timestep.
REQ-003 Parameter REFRAC, default 2: refractory length in cycles after a spike.
REQ-004 Parameter V_RESET, default 0: signed 8-bit membrane value loaded after a spike.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: synchronous, active-low reset.
REQ-007 Port in_valid, input, 1: a timestep's input spike vector and weights are present.
REQ-008 Port in_ready, output, 1: the block accepts a timestep; transfer occurs when in_valid and in_ready are both high on a clock edge.
REQ-009 Port in_spk, input, NUM_SYN: presynaptic spikes; bit i gates weight i.
REQ-010 Port weights, input, 8*NUM_SYN: packed signed 8-bit weights; weight i is bits [8i+7:8i].
REQ-011 Port spk_in, input, 1: spike decision from the downstream threshold comparator, driven combinationally from acc_out.
REQ-012 Port acc_out, output, 8 signed: membrane potential driven to the comparator.
REQ-013 Port out_valid, output, 1: one-cycle strobe; acc_out is final for the timestep and spk_in is sampled.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCUM, LEAK, CHECK and REFRAC; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE SHALL latch in_spk and weights on handshake, clear synapse index idx to 0, and go to ACCUM; idle cycles SHALL leave acc unchanged.
REQ-016 ACCUM SHALL process one synapse per cycle: if in_spk[idx] then acc <= sat(acc + weight[idx]), idx++; after idx = NUM_SYN-1 it SHALL go to LEAK (NUM_SYN cycles).
REQ-017 Addition SHALL use a 9-bit signed intermediate and clamp to [-128, +127] on every step, never wrapping.
REQ-018 LEAK (1 cycle) SHALL move acc toward zero: acc>0 -> acc - min(LEAK, acc); acc<0 -> acc + min(LEAK, -acc); acc=0 unchanged; leak never crosses zero.
REQ-019 CHECK (1 cycle) SHALL assert out_valid=1 with acc_out holding the post-leak value and sample spk_in in that cycle.
REQ-020 CHECK with spk_in=1 SHALL load acc <= V_RESET and go to REFRAC with counter = REFRAC; if REFRAC=0 it SHALL go directly to IDLE.
REQ-021 CHECK with spk_in=0 SHALL retain acc and go to IDLE; membrane potential persists across timesteps.
REQ-022 REFRAC SHALL decrement the counter each cycle, ignore in_valid and go to IDLE when the counter reaches 1 (exactly REFRAC cycles).
REQ-023 Latency SHALL be fixed: handshake at edge T -> out_valid high in cycle T+NUM_SYN+2 -> in_ready high again in cycle T+NUM_SYN+3 (no spike) or T+NUM_SYN+3+REFRAC (spike).
REQ-024 acc_out SHALL always equal the acc register; out_valid SHALL be 0 outside CHECK.
REQ-025 Changes on in_spk or weights after the handshake SHALL NOT affect the current timestep.

Reset
REQ-026 With rst_n=0 at an edge: state <= IDLE, acc <= 0, idx <= 0, refractory counter <= 0, out_valid <= 0; in_ready SHALL be 1 on the first cycle after release.
REQ-027 Reset in any state, including mid-ACCUM or REFRAC, SHALL abandon the timestep with no out_valid pulse.

Verification (NUM_SYN=4, LEAK=1, REFRAC=2, V_RESET=0, comparator threshold=10)
REQ-028 rst_n low 2 cycles -> acc_out=0, out_valid=0, in_ready=1 after release.
REQ-029 in_spk=0101, weights w0=4,w1=9,w2=7,w3=5 -> acc 11, leak 10; out_valid at T+6 with acc_out=10 and spk_in=1; then acc_out=0, in_ready=0 for 2 cycles, 1 at T+9.
REQ-030 in_spk=1111, all weights +100, from acc=0 -> clamps to 127, leak -> acc_out=126 at out_valid; all weights -100 -> -128, leak -> -127.
REQ-031 Two timesteps below threshold: in_spk=0001 with w0=3 twice -> acc_out 2 then 4, no reset, in_ready returns 1 at T+7 each time.
REQ-032 rst_n low in cycle T+2 (mid-ACCUM) -> acc_out=0, no out_valid pulse, in_ready=1 next cycle.
REQ-033 in_valid held high through REFRAC -> no acceptance while in_ready=0; accepted on the first IDLE edge; in_spk=0000 from acc=0 -> acc_out=0 at out_valid.
